// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared constants, state type and helpers for the round-robin mux arbiter
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Expand a requester index into its one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux_4x1.sv
// rtl/mux_4x1.sv - plain 4:1 single-bit multiplexer shared by the requesters
module mux_4x1 (
  input  logic [3:0] a,
  input  logic [1:0] sel,
  output logic       y
);

  assign y = a[sel];

endmodule

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational rotating-priority picker over four request lines
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  // Scan offsets from farthest to nearest so the nearest set bit past ptr wins.
  always_comb begin
    logic [SEL_W-1:0] cand;
    found = |req;
    idx   = ptr;
    cand  = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux_4x1_rr_arbiter.sv
// rtl/mux_4x1_rr_arbiter.sv - round-robin arbiter with burst limit driving a shared 4:1 mux select
module mux_4x1_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [SEL_W-1:0]    sel,
  output logic                busy
);

  localparam int                CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  arb_state_t          state;
  logic [SEL_W-1:0]    owner;
  logic [SEL_W-1:0]    ptr;
  logic [CNT_W-1:0]    cnt;

  logic [NUM_REQ-1:0]  owner_oh;
  logic [SEL_W-1:0]    next_ptr;
  logic [NUM_REQ-1:0]  pick_req;
  logic [SEL_W-1:0]    pick_ptr;
  logic                pick_found;
  logic [SEL_W-1:0]    pick_idx;
  logic                owner_req;
  logic                burst_done;

  assign owner_oh   = idx_to_onehot(owner);
  assign next_ptr   = owner + SEL_W'(1);
  assign owner_req  = req[owner];
  assign burst_done = (cnt == CNT_MAX);

  // While granted, the picker looks only at the other requesters, starting after the owner;
  // release and preempt both restart the search there, so one picker serves every case.
  always_comb begin
    pick_req = req;
    pick_ptr = ptr;
    if (state == GRANT) begin
      pick_req = req & ~owner_oh;
      pick_ptr = next_ptr;
    end
  end

  rr_pick4 u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Arbitration state machine; every output is a register so sel/gnt switch on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
      gnt   <= '0;
      sel   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state <= GRANT;
            owner <= pick_idx;
            cnt   <= CNT_ONE;
            gnt   <= idx_to_onehot(pick_idx);
            sel   <= pick_idx;
            busy  <= 1'b1;
          end
        end

        GRANT: begin
          if (!owner_req) begin
            // Owner released: hand off immediately or fall back to idle, sel left as-is.
            ptr <= next_ptr;
            if (pick_found) begin
              owner <= pick_idx;
              cnt   <= CNT_ONE;
              gnt   <= idx_to_onehot(pick_idx);
              sel   <= pick_idx;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
              cnt   <= '0;
              gnt   <= '0;
              busy  <= 1'b0;
            end
          end else if (burst_done && pick_found) begin
            // Burst used up and someone else waits: preempt, old owner re-competes later.
            ptr   <= next_ptr;
            owner <= pick_idx;
            cnt   <= CNT_ONE;
            gnt   <= idx_to_onehot(pick_idx);
            sel   <= pick_idx;
            busy  <= 1'b1;
          end else if (burst_done) begin
            // Nobody else waiting: owner simply starts a fresh burst.
            cnt <= CNT_ONE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_4x1_rr_arbiter.sv
// tb/tb_mux_4x1_rr_arbiter.sv - scoreboard bench for the arbiter feeding a 4:1 mux
module tb_mux_4x1_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] a;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       y;

  int total;
  int bad;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] a;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       y;
  } vec_t;

  typedef struct {
    int         id;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       y;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  mux_4x1_rr_arbiter #(.MAX_BURST(4)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .gnt  (gnt),
    .sel  (sel),
    .busy (busy)
  );

  mux_4x1 u_mux (
    .a   (a),
    .sel (sel),
    .y   (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input int n, input logic r, input logic [3:0] rq, input logic [3:0] av,
                     input logic [3:0] g, input logic [1:0] s, input logic b, input logic yy);
    vec_t v;
    v.rst = r; v.req = rq; v.a = av; v.gnt = g; v.sel = s; v.busy = b; v.y = yy;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic check(input int id, input string name, input logic [3:0] act, input logic [3:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL vec%0d %s got=%b want=%b", id, name, act, want);
    end
  endtask

  // Monitor: one output beat per clock, compared against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.id, "gnt",  gnt,          e.gnt);
        check(e.id, "sel",  {2'b00, sel}, {2'b00, e.sel});
        check(e.id, "busy", {3'b000, busy}, {3'b000, e.busy});
        check(e.id, "y",    {3'b000, y},  {3'b000, e.y});
      end
    end
  end

  // Stimulus: drive each vector on the falling edge and queue its expected result.
  initial begin
    exp_t e;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    req   = 4'b0000;
    a     = 4'b0000;

    // reset with all requesting, then full rotation with a=1010 (y = a[sel])
    add(3,  1'b1, 4'b1111, 4'b1010, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4,  1'b0, 4'b1111, 4'b1010, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(4,  1'b0, 4'b1111, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b1);
    add(4,  1'b0, 4'b1111, 4'b1010, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(4,  1'b0, 4'b1111, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b1);
    add(1,  1'b0, 4'b1111, 4'b1010, 4'b0001, 2'd0, 1'b1, 1'b0);
    // single requester burst beyond MAX_BURST, then release (sel holds 2)
    add(1,  1'b1, 4'b0000, 4'b1010, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(10, 1'b0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1);
    add(1,  1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
    add(1,  1'b0, 4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b1);
    // owner 2 (ptr=3) reaches cnt=3, mid-grant reset, then req=1100 must go to 2
    add(3,  1'b0, 4'b0100, 4'b1011, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(1,  1'b1, 4'b1100, 4'b1011, 4'b0000, 2'd0, 1'b0, 1'b1);
    add(1,  1'b0, 4'b1100, 4'b1011, 4'b0100, 2'd2, 1'b1, 1'b0);
    // early release: owner 1 drops after 2 cycles with 0 and 3 waiting -> 3 next
    add(1,  1'b0, 4'b0000, 4'b1011, 4'b0000, 2'd2, 1'b0, 1'b0);
    add(1,  1'b0, 4'b0010, 4'b1011, 4'b0010, 2'd1, 1'b1, 1'b1);
    add(1,  1'b0, 4'b1011, 4'b1011, 4'b0010, 2'd1, 1'b1, 1'b1);
    add(2,  1'b0, 4'b1001, 4'b1011, 4'b1000, 2'd3, 1'b1, 1'b1);
    add(1,  1'b0, 4'b0001, 4'b1011, 4'b0001, 2'd0, 1'b1, 1'b1);
    add(1,  1'b0, 4'b0000, 4'b1011, 4'b0000, 2'd0, 1'b0, 1'b1);
    // two requesters preempting each other every MAX_BURST cycles (ptr=1 at start)
    add(4,  1'b0, 4'b0101, 4'b1011, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(4,  1'b0, 4'b0101, 4'b1011, 4'b0001, 2'd0, 1'b1, 1'b1);
    add(1,  1'b0, 4'b0101, 4'b1011, 4'b0100, 2'd2, 1'b1, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst;
      req = vecs[i].req;
      a   = vecs[i].a;
      e.id   = i;
      e.gnt  = vecs[i].gnt;
      e.sel  = vecs[i].sel;
      e.busy = vecs[i].busy;
      e.y    = vecs[i].y;
      exp_q.push_back(e);
    end

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_4x1_rr_arbiter.md
# mux_4x1_rr_arbiter

- Round-robin arbiter that shares one 4:1 mux among four requesters.
- Drives the mux `sel` input so that exactly one requester's bit reaches `y` at a time.
- Each grant is held for at most `MAX_BURST` consecutive cycles, then ownership rotates to the next waiting requester.
- Sits directly in front of `mux_4x1`: arbiter `sel` connects to mux `sel`, requester data bits form mux `a`.

## Interface
- `MAX_BURST`, default 4: maximum consecutive cycles one requester may hold the grant. Legal range is 1..15.
- `clk`  input  1  rising-edge clock for all state.
- `rst`  input  1  reset, synchronous, active-high.
- `req`  input  4  request lines. Bit i is asserted by requester i.
- `gnt`  output  4  one-hot grant, registered. All zero when idle.
- `sel`  output  2  mux select, registered. Equals the index of the granted requester. Holds its last value when idle.
- `busy`  output  1  high when any grant is active. Equals `|gnt`.

## Operation
- States: IDLE and GRANT.
- Internal registers:
  - `owner`: 2-bit index of the current grant holder.
  - `ptr`: 2-bit search start, equal to last owner + 1 mod 4.
  - `cnt`: burst counter, width $clog2(MAX_BURST+1).
- Reset values:
  - state IDLE, `gnt`=0000, `sel`=00, `busy`=0.
  - `ptr`=0, `cnt`=0, `owner`=0.
- Pick function: the first set bit of `req` found by scanning `ptr`, `ptr`+1, … mod 4. There is no winner if `req`=0000.
- IDLE:
  - If `req`≠0, grant the pick: `owner`=pick, `cnt`=1, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT, evaluated on each edge in this priority order:
  1. `req[owner]`=0 (release):
     - Set `ptr`=`owner`+1.
     - If another request is pending, grant the pick with that new `ptr` immediately (`cnt`=1, no idle bubble).
     - Otherwise go to IDLE.
  2. `cnt`=`MAX_BURST` and another requester is pending (preempt):
     - Set `ptr`=`owner`+1 and grant the pick, `cnt`=1.
     - The preempted owner may keep `req` high; it re-competes in normal rotation.
  3. `cnt`=`MAX_BURST` and no other request is pending: the owner keeps the grant, `cnt`=1.
  4. Otherwise: `cnt`++.
- With `MAX_BURST`=1, every cycle rotates among the active requesters (pure round-robin).
- `sel` updates only when a new grant is issued, so the mux output stays stable across idle periods.
- A reset in the middle of a grant takes priority over everything: at the next edge all outputs return to their reset values, and `ptr`=0 gives requester 0 first priority again.

## Timing
- Latency from request to grant is 1 cycle: `req` sampled at edge N gives `gnt`/`sel` valid after edge N.
- Latency from release to the next grant is 1 cycle: `req[owner]` low at edge N gives the next owner's `gnt` after edge N. The old grant is never visible together with the new one.
- `gnt` is always one-hot or zero. `sel` and `gnt` change on the same edge.
- Maximum wait for any continuously requesting requester is 3×`MAX_BURST` cycles after its request is first sampled.
- Simultaneous release and preempt (`req[owner]` drops exactly when `cnt`=`MAX_BURST`) is handled as a release. The outcome is identical, since both set `ptr`=`owner`+1.
- `req` changes from non-owners during a grant have no effect until the next arbitration edge.

## Structure
- Package `mux_arb_pkg`:
  - `NUM_REQ`=4 and `SEL_W`=2.
  - State enum `arb_state_t` {IDLE, GRANT}.
- Sub-module `rr_pick4`: purely combinational. Inputs are `req`[4] and `ptr`[2]; outputs are `found` and `idx`[2].
  - It is used for both the idle grant and the in-GRANT arbitration; in GRANT it is fed `req` with the owner bit masked.
- The top level holds the state register, `cnt`, `owner`, `ptr` and the output registers. Outputs are driven directly from registers.
- The bench instantiates the arbiter together with `mux_4x1`, with `a`=requester data bits and `sel`=arbiter `sel`.

## Test plan
- Reset behaviour: hold `rst`=1 for 3 cycles with `req`=1111 → `gnt`=0000, `sel`=00, `busy`=0. Release reset → one cycle later `gnt`=0001, `sel`=00.
- Single requester burst, `MAX_BURST`=4: `req`=0100 held for 10 cycles → `gnt`=0100 and `sel`=10 continuously with no gaps. Drop `req` → `gnt`=0000 one cycle later and `sel` stays 10.
- Rotation: `req`=1111 held → grant sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0…, with `sel` following the same sequence.
- Early release handoff: owner 1 drops `req` after 2 cycles while `req`=1011 → next grant is 3, not 0, with no idle cycle between.
- Mid-grant reset: `rst`=1 while owner 2 has `cnt`=3 → next cycle `gnt`=0000. After `rst` is deasserted with `req`=1100 → grant goes to 2, because `ptr`=0 was restored.
- Datapath check: `a`=1010, `req`=1111 → mux `y` equals `a[sel]` on every cycle, and each requester gets exactly `MAX_BURST` cycles per rotation.
